// File: rtl/secp256k1_jb_to_affine.sv
`timescale 1ns/1ps
// Jacobian (x, y, z) to affine (x/z^2, y/z^3) converter for secp256k1.
// z^-1 comes from a binary extended-Euclid engine; scaling uses a shared multiplier.
module secp256k1_jb_to_affine #(
    parameter int INV_MAX_CYC = 1600
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [767:0] i_p,
    input  logic         i_err,
    input  logic         i_val,
    output logic         o_rdy,
    output logic [511:0] o_p,
    output logic         o_err,
    output logic         o_val,
    input  logic         i_rdy,
    output logic [255:0] o_mul_a,
    output logic [255:0] o_mul_b,
    output logic         o_mul_val,
    input  logic         i_mul_rdy,
    input  logic [255:0] i_mul_c,
    input  logic         i_mul_val,
    output logic         o_mul_rdy
);
    localparam logic [255:0] P =
        256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
    localparam logic [255:0] PH = P >> 1;
    localparam logic [10:0] CNT_MAX = 11'(INV_MAX_CYC - 1);

    typedef enum logic [1:0] {IDLE, INV, MUL, OUT} state_t;

    state_t       state_q;
    state_t       state_d;
    logic         live;
    logic [255:0] px;
    logic [255:0] py;
    logic [255:0] u;
    logic [255:0] v;
    logic [255:0] x1;
    logic [255:0] x2;
    logic [255:0] zinv;
    logic [255:0] m1;
    logic [255:0] rx;
    logic [255:0] ry;
    logic         ierr;
    logic         err;
    logic         wait_q;
    logic [1:0]   step;
    logic [10:0]  cnt;
    logic         accept;
    logic         u_one;
    logic         v_one;
    logic         mreq;
    logic [255:0] z_in;

    // (a + P) / 2 for odd a, written so no 257-bit intermediate is needed
    function automatic logic [255:0] halve(input logic [255:0] a);
        return a[0] ? (a >> 1) + PH + 256'd1 : a >> 1;
    endfunction

    function automatic logic [255:0] subm(input logic [255:0] a, input logic [255:0] b);
        return (a < b) ? a - b + P : a - b;
    endfunction

    assign z_in      = i_p[255:0];
    assign accept    = i_val && o_rdy;
    assign u_one     = (u == 256'd1);
    assign v_one     = (v == 256'd1);
    assign mreq      = (state_q == MUL) && !wait_q;
    assign o_rdy     = live && (state_q == IDLE);
    assign o_val     = (state_q == OUT);
    assign o_err     = o_val && (ierr || err);
    assign o_p       = {rx, ry};
    assign o_mul_val = mreq;
    // IDLE also drains any product left in flight across a reset
    assign o_mul_rdy = live && ((state_q == IDLE) || ((state_q == MUL) && wait_q));

    always_comb begin
        o_mul_a = '0;
        o_mul_b = '0;
        if (mreq) begin
            unique case (step)
                2'd0: begin o_mul_a = zinv; o_mul_b = zinv; end
                2'd1: begin o_mul_a = px;   o_mul_b = m1;   end
                2'd2: begin o_mul_a = m1;   o_mul_b = zinv; end
                default: begin o_mul_a = py; o_mul_b = m1;  end
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept) state_d = (z_in == '0) ? OUT : INV;
            INV: begin
                if (u_one || v_one) state_d = MUL;
                else if (cnt == CNT_MAX) state_d = OUT;
            end
            MUL: if (wait_q && i_mul_val && step == 2'd3) state_d = OUT;
            OUT: if (i_rdy) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            live   <= 1'b0;
            px     <= '0;
            py     <= '0;
            u      <= '0;
            v      <= '0;
            x1     <= '0;
            x2     <= '0;
            zinv   <= '0;
            m1     <= '0;
            rx     <= '0;
            ry     <= '0;
            ierr   <= 1'b0;
            err    <= 1'b0;
            wait_q <= 1'b0;
            step   <= '0;
            cnt    <= '0;
        end else begin
            live <= 1'b1;
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        px     <= i_p[767:512];
                        py     <= i_p[511:256];
                        ierr   <= i_err;
                        u      <= z_in;
                        v      <= P;
                        x1     <= 256'd1;
                        x2     <= '0;
                        cnt    <= '0;
                        step   <= '0;
                        wait_q <= 1'b0;
                        err    <= (z_in == '0);
                        rx     <= '0;
                        ry     <= '0;
                    end
                end
                INV: begin
                    cnt <= cnt + 11'd1;
                    // invariants: x1*z == u, x2*z == v (mod P)
                    if (u_one) begin
                        zinv <= x1;
                    end else if (v_one) begin
                        zinv <= x2;
                    end else if (cnt == CNT_MAX) begin
                        err <= 1'b1;
                        rx  <= '0;
                        ry  <= '0;
                    end else if (!u[0]) begin
                        u  <= u >> 1;
                        x1 <= halve(x1);
                    end else if (!v[0]) begin
                        v  <= v >> 1;
                        x2 <= halve(x2);
                    end else if (u >= v) begin
                        u  <= u - v;
                        x1 <= subm(x1, x2);
                    end else begin
                        v  <= v - u;
                        x2 <= subm(x2, x1);
                    end
                end
                MUL: begin
                    if (!wait_q) begin
                        if (i_mul_rdy) wait_q <= 1'b1;
                    end else if (i_mul_val) begin
                        wait_q <= 1'b0;
                        step   <= step + 2'd1;
                        unique case (step)
                            2'd0: m1 <= i_mul_c;
                            2'd1: rx <= i_mul_c;
                            2'd2: m1 <= i_mul_c;
                            default: ry <= i_mul_c;
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
